dmx_frame_sequencer: RTL and testbench

DMX_FRAME_SEQUENCER -- requirements
Module: dmx_frame_sequencer

---
 rtl/dmx_pkg.sv | 33 +++
 rtl/dmx_bit_timer.sv | 33 +++
 rtl/dmx_frame_sequencer.sv | 155 +++++++++++++++
 tb/tb_dmx_frame_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// Shared DMX512 definitions: state encoding, byte framing and default timing.
package dmx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_MAB,
    ST_START,
    ST_FETCH,
    ST_SLOT,
    ST_GAP
  } dmx_state_e;

  // start bit + 8 data bits + 2 stop bits
  localparam int BITS_PER_BYTE = 11;

  // 12 MHz clock, 250 kbaud line
  localparam int DEF_CLKS_PER_BIT = 48;
  localparam int DEF_BREAK_BITS   = 23;
  localparam int DEF_MAB_BITS     = 3;
  localparam int DEF_NUM_SLOTS    = 512;
  localparam int DEF_IDLE_BITS    = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for values 0..max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/dmx_bit_timer.sv
// Bit-time tick counter. Counts CLK12 cycles within one DMX bit while run is
// high and strobes bit_end on the last cycle of each bit. Held at zero while
// idle so every timed phase starts on a clean bit boundary.
module dmx_bit_timer
  import dmx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic CLK12,
  input  logic RESET_N,
  input  logic run,
  output logic bit_end
);

  localparam int TICK_W = cnt_width(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);

  logic [TICK_W-1:0] tick_q;

  assign bit_end = run && (tick_q == TICK_LAST);

  // Tick counter: wraps to zero at each bit boundary, cleared when not running.
  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_q <= '0;
    end else if (!run || bit_end) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + TICK_W'(1);
    end
  end

endmodule

// File: rtl/dmx_frame_sequencer.sv
// DMX512 transmit frame sequencer: break, mark-after-break, start code, then
// NUM_SLOTS bytes fetched one at a time from an external slot source.
//
// state  | meaning
// IDLE   | line at mark, waiting for ENABLE
// BREAK  | line low for BREAK_BITS bit times, start code latched on entry
// MAB    | line high for MAB_BITS bit times
// START  | start-code byte on the line
// FETCH  | SLOT_REQ high, line at mark until SLOT_VALID
// SLOT   | fetched slot byte on the line
// GAP    | FRAME_DONE cycle plus IDLE_BITS bit times of mark
module dmx_frame_sequencer
  import dmx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int BREAK_BITS   = DEF_BREAK_BITS,
  parameter int MAB_BITS     = DEF_MAB_BITS,
  parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int IDLE_BITS    = DEF_IDLE_BITS
) (
  input  logic       CLK12,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic [7:0] START_CODE,
  output logic       SLOT_REQ,
  output logic [8:0] SLOT_ADDR,
  input  logic [7:0] SLOT_DATA,
  input  logic       SLOT_VALID,
  output logic       DMX_DATA,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  localparam int BIT_MAX = max_int(max_int(BREAK_BITS, MAB_BITS),
                                   max_int(BITS_PER_BYTE, IDLE_BITS));
  localparam int BIT_W   = cnt_width(BIT_MAX);

  localparam logic [BIT_W-1:0] BREAK_LAST = BIT_W'(BREAK_BITS - 1);
  localparam logic [BIT_W-1:0] MAB_LAST   = BIT_W'(MAB_BITS - 1);
  localparam logic [BIT_W-1:0] BYTE_LAST  = BIT_W'(BITS_PER_BYTE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(8);
  localparam logic [BIT_W-1:0] GAP_LAST   = BIT_W'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);
  localparam logic [8:0]       ADDR_LAST  = 9'(NUM_SLOTS - 1);
  localparam logic             GAP_TIMED  = (IDLE_BITS > 0);

  dmx_state_e       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [8:0]       slot_addr_q;
  logic [7:0]       tx_shift_q;
  logic [7:0]       start_code_q;
  logic             frame_done_q;

  logic timer_run;
  logic bit_end;
  logic byte_state;
  logic byte_end;
  logic gap_end;

  assign byte_state = (state_q == ST_START) || (state_q == ST_SLOT);
  assign timer_run  = byte_state || (state_q == ST_BREAK) || (state_q == ST_MAB) ||
                      ((state_q == ST_GAP) && GAP_TIMED);
  assign byte_end   = bit_end && (bit_cnt_q == BYTE_LAST);
  // With no idle time the GAP state lasts only its FRAME_DONE cycle.
  assign gap_end    = !GAP_TIMED || (bit_end && (bit_cnt_q == GAP_LAST));

  dmx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK12  (CLK12),
    .RESET_N(RESET_N),
    .run    (timer_run),
    .bit_end(bit_end)
  );

  // State register.
  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; ENABLE is only consulted between frames.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ENABLE) state_d = ST_BREAK;
      ST_BREAK: if (bit_end && (bit_cnt_q == BREAK_LAST)) state_d = ST_MAB;
      ST_MAB:   if (bit_end && (bit_cnt_q == MAB_LAST)) state_d = ST_START;
      ST_START: if (byte_end) state_d = ST_FETCH;
      ST_FETCH: if (SLOT_VALID) state_d = ST_SLOT;
      ST_SLOT:  if (byte_end) state_d = (slot_addr_q == ADDR_LAST) ? ST_GAP : ST_FETCH;
      ST_GAP:   if (gap_end) state_d = ENABLE ? ST_BREAK : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bit counter, slot address, byte shifter, latched start code, done pulse.
  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt_q    <= '0;
      slot_addr_q  <= '0;
      tx_shift_q   <= '0;
      start_code_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state_q == ST_SLOT) && (state_d == ST_GAP);

      if (state_d != state_q) begin
        bit_cnt_q <= '0;
      end else if (bit_end) begin
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end

      if ((state_d == ST_BREAK) && (state_q != ST_BREAK)) begin
        start_code_q <= START_CODE;
      end

      if ((state_q == ST_START) && (state_d == ST_FETCH)) begin
        slot_addr_q <= '0;
      end else if ((state_q == ST_SLOT) && (state_d == ST_FETCH)) begin
        slot_addr_q <= slot_addr_q + 9'd1;
      end

      if ((state_q == ST_MAB) && (state_d == ST_START)) begin
        tx_shift_q <= start_code_q;
      end else if ((state_q == ST_FETCH) && SLOT_VALID) begin
        tx_shift_q <= SLOT_DATA;
      end else if (byte_state && bit_end && (bit_cnt_q != '0) && (bit_cnt_q <= DATA_LAST)) begin
        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
      end
    end
  end

  // Line level: low for break and start bits, LSB-first data, mark elsewhere.
  always_comb begin
    DMX_DATA = 1'b1;
    if (state_q == ST_BREAK) begin
      DMX_DATA = 1'b0;
    end else if (byte_state) begin
      if (bit_cnt_q == '0) begin
        DMX_DATA = 1'b0;
      end else if (bit_cnt_q <= DATA_LAST) begin
        DMX_DATA = tx_shift_q[0];
      end
    end
  end

  assign SLOT_REQ   = (state_q == ST_FETCH);
  assign SLOT_ADDR  = slot_addr_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_dmx_frame_sequencer.sv
// Bench for dmx_frame_sequencer: frames described by a vector table, line
// decoded by a bit-sampling receiver, slot bytes tracked in a scoreboard.
module tb_dmx_frame_sequencer;

  localparam int CPB       = 4;
  localparam int NS        = 3;
  localparam int NROWS     = 5;
  localparam int EXP_BREAK = 92;
  localparam int EXP_MAB   = 12;

  logic       CLK12;
  logic       RESET_N;
  logic       ENABLE;
  logic [7:0] START_CODE;
  logic       SLOT_REQ;
  logic [8:0] SLOT_ADDR;
  logic [7:0] SLOT_DATA;
  logic       SLOT_VALID;
  logic       DMX_DATA;
  logic       BUSY;
  logic       FRAME_DONE;

  typedef struct {
    logic [7:0]      sc;
    logic [2:0][7:0] data;
    logic [2:0][7:0] lat;
    logic            drop_en;
    int              exp_done;
  } vec_t;

  vec_t       vec [NROWS];
  logic [7:0] sc_q [$];
  logic [7:0] slot_q [$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         fd_cnt = 0;

  dmx_frame_sequencer #(
    .CLKS_PER_BIT(CPB),
    .BREAK_BITS  (23),
    .MAB_BITS    (3),
    .NUM_SLOTS   (NS),
    .IDLE_BITS   (0)
  ) dut (
    .CLK12     (CLK12),
    .RESET_N   (RESET_N),
    .ENABLE    (ENABLE),
    .START_CODE(START_CODE),
    .SLOT_REQ  (SLOT_REQ),
    .SLOT_ADDR (SLOT_ADDR),
    .SLOT_DATA (SLOT_DATA),
    .SLOT_VALID(SLOT_VALID),
    .DMX_DATA  (DMX_DATA),
    .BUSY      (BUSY),
    .FRAME_DONE(FRAME_DONE)
  );

  initial CLK12 = 1'b0;
  always #5 CLK12 = ~CLK12;

  always @(posedge CLK12) cyc <= cyc + 1;
  always @(negedge CLK12) if (FRAME_DONE === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] sc, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] d2, input int l0,
                         input int l1, input int l2, input logic drop, input int done);
    vec[i].sc       = sc;
    vec[i].data[0]  = d0;
    vec[i].data[1]  = d1;
    vec[i].data[2]  = d2;
    vec[i].lat[0]   = 8'(l0);
    vec[i].lat[1]   = 8'(l1);
    vec[i].lat[2]   = 8'(l2);
    vec[i].drop_en  = drop;
    vec[i].exp_done = done;
  endtask

  // Step to the first negedge where the line is at lvl, within a cycle budget.
  task automatic wait_level(input logic lvl, input int budget);
    int n;
    n = 0;
    while (DMX_DATA !== lvl && n < budget) begin
      @(negedge CLK12);
      n++;
    end
    check("wait_line_level", DMX_DATA, lvl);
  endtask

  // Count cycles the line stays at lvl; returns at the first cycle it differs.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (DMX_DATA === lvl && n < 5000) begin
      n++;
      @(negedge CLK12);
    end
  endtask

  // Receive one 11-bit character starting at the first start-bit cycle.
  task automatic read_byte(output logic [7:0] b, output logic ok);
    logic [10:0] bits;
    bits = '0;
    ok = 1'b1;
    for (int c = 0; c < 11 * CPB; c++) begin
      if (c > 0) @(negedge CLK12);
      if (c % CPB == 0) bits[c / CPB] = DMX_DATA;
      else if (DMX_DATA !== bits[c / CPB]) ok = 1'b0;
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[10] !== 1'b1) ok = 1'b0;
    b = bits[8:1];
  endtask

  task automatic run_frame(input int i);
    int         n;
    int         t0;
    int         fd0;
    logic [7:0] b;
    logic [7:0] exp_b;
    logic       ok;
    wait_level(1'b0, 2000);
    t0  = cyc;
    fd0 = fd_cnt;
    // Change the start code during BREAK; it must only show up next frame.
    if (i + 1 < NROWS) begin
      START_CODE = vec[i + 1].sc;
      sc_q.push_back(vec[i + 1].sc);
    end
    run_len(1'b0, n);
    check("break_len", n, EXP_BREAK);
    run_len(1'b1, n);
    check("mab_len", n, EXP_MAB);
    read_byte(b, ok);
    check("start_code_framing", ok, 1'b1);
    check("sc_q_nonempty", sc_q.size() > 0, 1'b1);
    if (sc_q.size() > 0) begin
      exp_b = sc_q.pop_front();
      check("start_code", b, exp_b);
    end
    for (int s = 0; s < NS; s++) begin
      wait_level(1'b0, 500);
      if (s == 0 && vec[i].drop_en) ENABLE = 1'b0;
      read_byte(b, ok);
      check("slot_framing", ok, 1'b1);
      check("slot_q_nonempty", slot_q.size() > 0, 1'b1);
      if (slot_q.size() > 0) begin
        exp_b = slot_q.pop_front();
        check("slot_byte", b, exp_b);
      end
    end
    @(negedge CLK12);
    check("frame_done_pulse", FRAME_DONE, 1'b1);
    check("frame_done_time", cyc - t0, vec[i].exp_done);
    @(negedge CLK12);
    check("frame_done_width", FRAME_DONE, 1'b0);
    check("done_count", fd_cnt - fd0, 1);
    check("line_after_done", DMX_DATA, vec[i].drop_en ? 1'b1 : 1'b0);
    check("busy_after_done", BUSY, vec[i].drop_en ? 1'b0 : 1'b1);
  endtask

  // Slot source: per-row latency, spurious SLOT_VALID while no request.
  initial begin : responder
    int   wait_n;
    int   fidx;
    int   f;
    int   eaddr;
    logic served;
    wait_n = 0;
    fidx   = 0;
    eaddr  = 0;
    served = 1'b0;
    SLOT_VALID = 1'b0;
    SLOT_DATA  = 8'h00;
    forever begin
      @(negedge CLK12);
      if (served) begin
        check("req_drop_after_capture", SLOT_REQ, 1'b0);
        check("start_bit_after_capture", DMX_DATA, 1'b0);
        served = 1'b0;
      end
      SLOT_VALID = 1'b0;
      f = (fidx < NROWS) ? fidx : NROWS - 1;
      if (SLOT_REQ === 1'b1) begin
        check("slot_addr", SLOT_ADDR, eaddr);
        if (wait_n < int'(vec[f].lat[eaddr])) begin
          check("mark_while_waiting", DMX_DATA, 1'b1);
          wait_n++;
        end else begin
          SLOT_DATA  = vec[f].data[eaddr];
          SLOT_VALID = 1'b1;
          slot_q.push_back(vec[f].data[eaddr]);
          wait_n = 0;
          served = 1'b1;
          if (eaddr == NS - 1) begin
            eaddr = 0;
            fidx++;
          end else begin
            eaddr++;
          end
        end
      end else begin
        SLOT_VALID = ($urandom_range(0, 3) == 0);
        SLOT_DATA  = 8'h5A;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

  initial begin : main
    int bad;
    //          row sc     d0     d1     d2    l0 l1  l2 drop done
    set_vec(0, 8'h00, 8'hA5, 8'h01, 8'hFF, 0, 0,  0, 1'b0, 283);
    set_vec(1, 8'h55, 8'h3C, 8'hC3, 8'h80, 0, 10, 0, 1'b0, 293);
    set_vec(2, 8'hCC, 8'h00, 8'h7E, 8'h01, 3, 0,  5, 1'b0, 291);
    set_vec(3, 8'h17, 8'hFF, 8'h00, 8'hAA, 0, 0,  0, 1'b1, 283);
    set_vec(4, 8'h42, 8'h11, 8'h22, 8'h33, 0, 0,  0, 1'b1, 283);

    ENABLE     = 1'b0;
    START_CODE = vec[0].sc;
    sc_q.push_back(vec[0].sc);
    RESET_N = 1'b1;
    #1 RESET_N = 1'b0;
    repeat (3) @(negedge CLK12);
    check("reset_dmx", DMX_DATA, 1'b1);
    check("reset_busy", BUSY, 1'b0);
    check("reset_req", SLOT_REQ, 1'b0);
    check("reset_addr", SLOT_ADDR, 9'd0);
    check("reset_done", FRAME_DONE, 1'b0);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLK12);
    check("idle_without_enable", BUSY, 1'b0);
    ENABLE = 1'b1;

    for (int i = 0; i < 4; i++) run_frame(i);

    // ENABLE dropped in row 3: no further BREAK.
    bad = 0;
    repeat (200) begin
      @(negedge CLK12);
      if (DMX_DATA !== 1'b1 || BUSY !== 1'b0) bad++;
    end
    check("stays_idle", bad, 0);

    // Reset in the middle of BREAK, then a fresh full-length frame.
    ENABLE = 1'b1;
    wait_level(1'b0, 100);
    repeat (30) @(negedge CLK12);
    check("pre_reset_break", DMX_DATA, 1'b0);
    #2 RESET_N = 1'b0;
    #1;
    check("async_reset_dmx", DMX_DATA, 1'b1);
    check("async_reset_busy", BUSY, 1'b0);
    check("async_reset_req", SLOT_REQ, 1'b0);
    check("async_reset_addr", SLOT_ADDR, 9'd0);
    @(negedge CLK12);
    check("held_reset_busy", BUSY, 1'b0);
    RESET_N = 1'b1;
    run_frame(4);

    check("scoreboard_drained", sc_q.size() + slot_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
